// File: rtl/anubis_lin_mix_pkg.sv
// anubis_pkg: GF(2^8) constants, mixing matrices, modes and FSM encodings for the linear-mix engine
package anubis_pkg;
  localparam logic [8:0] GF_POLY = 9'h11D;
  localparam logic MODE_THETA = 1'b0;
  localparam logic MODE_OMEGA = 1'b1;
  typedef logic [0:3][7:0] row_t;
  typedef logic [0:3][0:3][7:0] mat_t;
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_DONE = 2'd2;
  localparam mat_t H_MAT = 128'h01020406_02010604_04060102_06040201;
  localparam mat_t V_MAT = 128'h01010101_01020406_01041014_01084078;
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY[7:0] : 8'h00);
  endfunction
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] c);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r = c[i] ? r ^ p : r;
      p = xtime(p);
    end
    return r;
  endfunction
endpackage

// File: rtl/anubis_lin_mix_if.sv
// anubis_lin_mix_if: valid/ready request and response channels of the linear-mix engine
interface anubis_lin_mix_if #(parameter int DATA_W = 128);
  logic              in_valid;
  logic              in_ready;
  logic              in_mode;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  modport master(output in_valid, in_mode, in_data, out_ready, input in_ready, out_valid, out_data, busy);
  modport slave(input in_valid, in_mode, in_data, out_ready, output in_ready, out_valid, out_data, busy);
endinterface

// File: rtl/anubis_lin_mix_mix_row.sv
// anubis_mix_row: one result row of theta (a*H) or omega (V*a) from the latched state
module anubis_mix_row
  import anubis_pkg::*;
(
  input  mat_t       st,
  input  logic [1:0] row,
  input  logic       mode,
  output row_t       res
);
  // theta mixes within the selected row; omega mixes down each column
  always_comb begin
    res = '0;
    for (int j = 0; j < 4; j++)
      for (int k = 0; k < 4; k++)
        res[j] = res[j] ^ (mode == MODE_OMEGA ? gf_mul(st[k][j], V_MAT[row][k]) : gf_mul(st[row][k], H_MAT[k][j]));
  end
endmodule

// File: rtl/anubis_lin_mix.sv
// anubis_lin_mix: iterative handshaked theta/omega GF(2^8) mixing engine
module anubis_lin_mix
  import anubis_pkg::*;
#(
  parameter int ROWS_PER_CYCLE = 1,
  parameter int DATA_W = 128
) (
  input logic clk,
  input logic rst,
  anubis_lin_mix_if.slave bus
);
  localparam int N = ROWS_PER_CYCLE;
  if (!(N == 1 || N == 2 || N == 4) || DATA_W != 128) begin : g_bad
    $error("anubis_lin_mix: ROWS_PER_CYCLE must be 1, 2 or 4 and DATA_W 128");
  end
  state_t     state;
  mat_t       st_r;
  mat_t       out_r;
  logic       mode_r;
  logic [1:0] row_cnt;
  logic [1:0] row_idx [N];
  row_t       row_res [N];
  logic       last_row;
  for (genvar r = 0; r < N; r++) begin : g_row
    assign row_idx[r] = row_cnt + 2'(r);
    anubis_mix_row u_row (.st(st_r), .row(row_idx[r]), .mode(mode_r), .res(row_res[r]));
  end
  assign last_row      = (row_cnt + 2'(N - 1)) == 2'd3;
  assign bus.in_ready  = state == ST_IDLE && !rst;
  assign bus.out_valid = state == ST_DONE;
  assign bus.busy      = state != ST_IDLE;
  assign bus.out_data  = out_r;
  // accept a block, fill N result rows per cycle, then hold the result until taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      st_r    <= '0;
      mode_r  <= MODE_THETA;
      row_cnt <= '0;
      out_r   <= '0;
    end else if (state == ST_IDLE) begin
      if (bus.in_valid) begin
        st_r    <= bus.in_data;
        mode_r  <= bus.in_mode;
        row_cnt <= '0;
        out_r   <= '0;
        state   <= ST_CALC;
      end
    end else if (state == ST_CALC) begin
      for (int r = 0; r < N; r++) out_r[row_idx[r]] <= row_res[r];
      row_cnt <= row_cnt + 2'(N);
      state   <= last_row ? ST_DONE : ST_CALC;
    end else begin
      state <= (state == ST_DONE && !bus.out_ready) ? ST_DONE : ST_IDLE;
    end
  end
endmodule

// File: doc/anubis_lin_mix.md
Name: anubis_lin_mix

Overview:
- Iterative, handshaked GF(2^8) linear-mixing engine for the Anubis datapath.
- Computes either the round diffusion theta (b = a·H) or the key extraction omega (b = V·a) on one 128-bit 4x4 byte state.
- Successor to the fixed single-function, free-running theta/omega blocks: one shared engine, runtime mode select, configurable rows-per-cycle throughput and valid/ready flow control.
- Sits between the round-function/key-schedule controllers and the state registers.

Parameters:
- ROWS_PER_CYCLE, 1, output rows computed per CALC cycle. Legal values: 1, 2, 4; any other value is an elaboration error.
- DATA_W, 128, state width. Fixed at 16 bytes; present for port sizing only.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  input word and mode are valid.
- in_ready  out  1  engine accepts input this cycle.
- in_mode  in  1  0 = theta, 1 = omega; sampled on accept.
- in_data  in  DATA_W  input state.
- out_valid  out  1  result valid; held until taken.
- out_ready  in  1  consumer takes the result.
- out_data  out  DATA_W  result state.
- busy  out  1  high in CALC or DONE.

Behaviour:
- Byte map: byte n = in_data[127-8n -: 8]; a[i][j] = byte 4i+j (row-major). out_data uses the same map.
- GF(2^8) multiplication uses polynomial 0x11D.
- H = had(01,02,04,06):
  - row0 = 01 02 04 06
  - row1 = 02 01 06 04
  - row2 = 04 06 01 02
  - row3 = 06 04 02 01
- Theta: b[i][j] = XOR over k of a[i][k]·H[k][j].
- V[i][j] = c_j^i, with c = {01,02,04,06}. Omega: b[i][j] = XOR over k of V[i][k]·a[k][j].
- FSM states: IDLE, CALC, DONE.
  - IDLE: in_ready = 1. On in_valid, latch in_data and in_mode, clear the row counter and output register, go to CALC.
  - CALC: each cycle write ROWS_PER_CYCLE result rows (starting at the row counter) into the output register, then advance the counter by ROWS_PER_CYCLE. After the write of row 3, go to DONE.
  - DONE: out_valid = 1. If out_ready, go to IDLE.
- Latency: out_valid rises 4/ROWS_PER_CYCLE cycles after the accept edge.
- Throughput: one block per 4/ROWS_PER_CYCLE + 2 cycles.
- in_ready = 1 only in IDLE. in_valid outside IDLE is ignored; the source must hold its data until accepted.
- out_data is stable throughout DONE. out_valid with out_ready low holds indefinitely with no change.
- Input changes after accept have no effect on the block in progress.
- The row counter wraps modulo 4. It is only ever compared against the last row index.
- Reset values (any time, including mid-CALC or mid-DONE, with immediate effect): state = IDLE, out_valid = 0, out_data = 0, busy = 0, in_ready = 0 while rst is high, latched mode = 0, row counter = 0. A block in flight is discarded.

Decomposition:
- Package anubis_pkg holds:
  - GF_POLY = 9'h11D
  - H_MAT and V_MAT as 4x4 byte constant arrays
  - MODE_THETA / MODE_OMEGA encodings
  - FSM state typedef
- Sub-module anubis_mix_row:
  - combinational; computes one result row from the latched state, a row index and the mode, using constant xtime-based multipliers
  - instantiated ROWS_PER_CYCLE times

Test Plan:
- RPC=1, theta, in_data = 0x01000000_00000000_00000000_00000000 -> out_data = 0x01020406_00000000_00000000_00000000; out_valid rises 4 cycles after accept.
- RPC=4, theta, all bytes 0x01 -> all bytes 0x01, out_valid 1 cycle after accept. Omega, all bytes 0x01 -> rows 0x00, 0x01, 0x01, 0x31 (each row uniform).
- Omega, byte0 = 0x01, rest 0 -> bytes 0, 4, 8 and 12 = 0x01, all others 0x00; check RPC=1, 2 and 4 give identical results.
- Backpressure: out_ready low for 10 cycles -> out_valid and out_data constant, in_ready = 0. Assert out_ready -> IDLE next cycle, in_ready = 1.
- Assert rst during the second CALC cycle -> out_valid and out_data = 0 immediately, IDLE after release. The next block processes correctly.
- Golden-file regression: the existing omega and theta vector files are fed through the valid/ready handshake in both modes with random out_ready stalls; every result must match.
